rx_buff_rd_ctrl: RTL

//  Read-side controller of the RX ring buffer. Consumes the committed write address, already synchronised into this clock domain.

---
 rtl/rx_buff_rd_if.sv | 27 ++
 rtl/rx_buff_rd_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rx_buff_rd_if.sv
// Burst request/completion handshake between the RX buffer read controller (master)
// and the read-side DMA/TLP engine (slave).
interface rx_buff_rd_if #(
    parameter int unsigned AW = 10
) ();
    logic          burst_req_valid;
    logic [AW-1:0] burst_addr;
    logic [AW-1:0] burst_len;
    logic          burst_ack;
    logic          burst_done;

    modport master (
        output burst_req_valid,
        output burst_addr,
        output burst_len,
        input  burst_ack,
        input  burst_done
    );

    modport slave (
        input  burst_req_valid,
        input  burst_addr,
        input  burst_len,
        output burst_ack,
        output burst_done
    );
endinterface

// File: rtl/rx_buff_rd_ctrl.sv
// Read-side controller of the RX ring buffer: issues bounded, non-wrapping read bursts and
// returns the committed read address. Optional feature macro: RX_RD_COMMIT_HOLD_EN (post-commit hold).
module rx_buff_rd_ctrl #(
    parameter int unsigned AW        = 10,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] commited_wr_address_in,
    rx_buff_rd_if.master  bus,
    output logic [AW-1:0] commited_rd_address_out,
    output logic          busy
);

    localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] MAX_LEN = AW'(MAX_BURST);

`ifdef RX_RD_COMMIT_HOLD_EN
    localparam int unsigned HOLD_CW   = 2;
    localparam logic [HOLD_CW-1:0] HOLD_LAST = HOLD_CW'(3);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_REQ    = 5'b00010,
        S_WAIT   = 5'b00100,
        S_COMMIT = 5'b01000,
        S_HOLD   = 5'b10000
    } state_e;
`else
    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_REQ    = 4'b0010,
        S_WAIT   = 4'b0100,
        S_COMMIT = 4'b1000
    } state_e;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] wr_reg_q, wr_reg_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] burst_addr_q, burst_addr_d;
    logic [AW-1:0] burst_len_q, burst_len_d;
    logic [AW-1:0] commit_q, commit_d;
    logic          req_valid_q, req_valid_d;
    logic          busy_q, busy_d;
`ifdef RX_RD_COMMIT_HOLD_EN
    logic [HOLD_CW-1:0] hold_cnt_q, hold_cnt_d;
`endif

    logic [AW-1:0] avail;
    logic [AW:0]   to_end;
    logic [AW-1:0] len_cap;
    logic [AW-1:0] len_next;
    logic          have_data;

    // Burst length: pending words, clipped to MAX_BURST and to the wrap point.
    always_comb begin : len_calc
        avail     = wr_reg_q - rd_ptr_q;
        have_data = (avail != '0);
        to_end    = DEPTH - {1'b0, rd_ptr_q};
        len_cap   = (avail < MAX_LEN) ? avail : MAX_LEN;
        len_next  = ({1'b0, len_cap} > to_end) ? to_end[AW-1:0] : len_cap;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin : regs
        if (reset) begin
            state_q      <= S_IDLE;
            wr_reg_q     <= '0;
            rd_ptr_q     <= '0;
            burst_addr_q <= '0;
            burst_len_q  <= '0;
            commit_q     <= '0;
            req_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef RX_RD_COMMIT_HOLD_EN
            hold_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_reg_q     <= wr_reg_d;
            rd_ptr_q     <= rd_ptr_d;
            burst_addr_q <= burst_addr_d;
            burst_len_q  <= burst_len_d;
            commit_q     <= commit_d;
            req_valid_q  <= req_valid_d;
            busy_q       <= busy_d;
`ifdef RX_RD_COMMIT_HOLD_EN
            hold_cnt_q   <= hold_cnt_d;
`endif
        end
    end

    // Next-state logic; done is only honoured in WAIT, so ack+done in REQ drops the done.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (have_data) state_d = S_REQ;
            S_REQ:    if (bus.burst_ack) state_d = S_WAIT;
            S_WAIT:   if (bus.burst_done) state_d = S_COMMIT;
`ifdef RX_RD_COMMIT_HOLD_EN
            S_COMMIT: state_d = S_HOLD;
            S_HOLD:   if (hold_cnt_q == HOLD_LAST) state_d = S_IDLE;
`else
            S_COMMIT: state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath updates for each state.
    always_comb begin : out_logic
        wr_reg_d     = commited_wr_address_in;
        rd_ptr_d     = rd_ptr_q;
        burst_addr_d = burst_addr_q;
        burst_len_d  = burst_len_q;
        commit_d     = commit_q;
        req_valid_d  = req_valid_q;
        busy_d       = (state_d != S_IDLE);
`ifdef RX_RD_COMMIT_HOLD_EN
        hold_cnt_d   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (have_data) begin
                    req_valid_d  = 1'b1;
                    burst_addr_d = rd_ptr_q;
                    burst_len_d  = len_next;
                end
            end
            S_REQ: begin
                if (bus.burst_ack) req_valid_d = 1'b0;
            end
            S_WAIT: begin
                if (bus.burst_done) rd_ptr_d = rd_ptr_q + burst_len_q;
            end
            S_COMMIT: begin
                commit_d = rd_ptr_q;
            end
`ifdef RX_RD_COMMIT_HOLD_EN
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_CW'(1);
            end
`endif
            default: ;
        endcase
    end

    assign bus.burst_req_valid      = req_valid_q;
    assign bus.burst_addr           = burst_addr_q;
    assign bus.burst_len            = burst_len_q;
    assign commited_rd_address_out  = commit_q;
    assign busy                     = busy_q;

endmodule
